mc_ctrl: RTL

//  Multi-cycle sequencer for the MIPS datapath: FSM over FETCH/DECODE/EXEC/MEM/WB, one datapath step per state.

---
 rtl/mc_ctrl_pkg.sv | 93 +++++++++
 rtl/mc_decode.sv | 77 +++++++
 rtl/mc_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller:
// FSM states, ALU codes, mux selects and opcode/funct values.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEMRD,
    S_MEMWR,
    S_WB_ALU,
    S_WB_MEM
  } state_t;

  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_NOR  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8;
  localparam logic [3:0] ALU_LUI  = 4'd9;
  localparam logic [3:0] ALU_SLL  = 4'd10;
  localparam logic [3:0] ALU_SRL  = 4'd11;
  localparam logic [3:0] ALU_SRA  = 4'd12;
  localparam logic [3:0] ALU_SLLV = 4'd13;
  localparam logic [3:0] ALU_SRLV = 4'd14;
  localparam logic [3:0] ALU_SRAV = 4'd15;

  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JREG   = 2'b11;

  localparam logic [1:0] GPRSel_RD = 2'b00;
  localparam logic [1:0] GPRSel_RT = 2'b01;
  localparam logic [1:0] GPRSel_RA = 2'b10;

  localparam logic [1:0] WDSel_ALU = 2'b00;
  localparam logic [1:0] WDSel_MDR = 2'b01;
  localparam logic [1:0] WDSel_PC  = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  typedef struct packed {
    logic r_alu;
    logic shift;
    logic i_alu;
    logic lw;
    logic sw;
    logic br;
    logic j;
    logic jal;
    logic jr;
    logic jalr;
  } cls_t;

endpackage

// File: rtl/mc_decode.sv
// Instruction class decoder: Op/Funct to one-hot class,
// ALU function code and immediate extension mode.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output cls_t       cls,
  output logic       is_bne,
  output logic [3:0] alu_op,
  output logic       ext_op
);

  // Pure table lookup; an all-zero class means undecodable.
  always_comb begin
    cls    = '0;
    is_bne = 1'b0;
    alu_op = ALU_NOP;
    ext_op = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_SLL:  begin cls.shift = 1'b1; alu_op = ALU_SLL; end
          FN_SRL:  begin cls.shift = 1'b1; alu_op = ALU_SRL; end
          FN_SRA:  begin cls.shift = 1'b1; alu_op = ALU_SRA; end
          FN_SLLV: begin cls.r_alu = 1'b1; alu_op = ALU_SLLV; end
          FN_SRLV: begin cls.r_alu = 1'b1; alu_op = ALU_SRLV; end
          FN_SRAV: begin cls.r_alu = 1'b1; alu_op = ALU_SRAV; end
          FN_ADD,
          FN_ADDU: begin cls.r_alu = 1'b1; alu_op = ALU_ADD; end
          FN_SUB,
          FN_SUBU: begin cls.r_alu = 1'b1; alu_op = ALU_SUB; end
          FN_AND:  begin cls.r_alu = 1'b1; alu_op = ALU_AND; end
          FN_OR:   begin cls.r_alu = 1'b1; alu_op = ALU_OR; end
          FN_XOR:  begin cls.r_alu = 1'b1; alu_op = ALU_XOR; end
          FN_NOR:  begin cls.r_alu = 1'b1; alu_op = ALU_NOR; end
          FN_SLT:  begin cls.r_alu = 1'b1; alu_op = ALU_SLT; end
          FN_SLTU: begin cls.r_alu = 1'b1; alu_op = ALU_SLTU; end
          FN_JR:   cls.jr = 1'b1;
          FN_JALR: cls.jalr = 1'b1;
          default: ;
        endcase
      end
      OP_J:   cls.j = 1'b1;
      OP_JAL: cls.jal = 1'b1;
      OP_BEQ: begin
        cls.br = 1'b1; alu_op = ALU_SUB; ext_op = 1'b1;
      end
      OP_BNE: begin
        cls.br = 1'b1; is_bne = 1'b1;
        alu_op = ALU_SUB; ext_op = 1'b1;
      end
      OP_ADDI,
      OP_ADDIU: begin
        cls.i_alu = 1'b1; alu_op = ALU_ADD; ext_op = 1'b1;
      end
      OP_SLTI: begin
        cls.i_alu = 1'b1; alu_op = ALU_SLT; ext_op = 1'b1;
      end
      OP_SLTIU: begin
        cls.i_alu = 1'b1; alu_op = ALU_SLTU; ext_op = 1'b1;
      end
      OP_ANDI: begin cls.i_alu = 1'b1; alu_op = ALU_AND; end
      OP_ORI:  begin cls.i_alu = 1'b1; alu_op = ALU_OR; end
      OP_XORI: begin cls.i_alu = 1'b1; alu_op = ALU_XOR; end
      OP_LUI:  begin cls.i_alu = 1'b1; alu_op = ALU_LUI; end
      OP_LW: begin
        cls.lw = 1'b1; alu_op = ALU_ADD; ext_op = 1'b1;
      end
      OP_SW: begin
        cls.sw = 1'b1; alu_op = ALU_ADD; ext_op = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS sequencer: FSM, memory wait counter
// and per-state datapath enables over a shared memory port.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int RA_REG   = 31,
  parameter int WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic [1:0] NPCOp,
  output logic       RegWrite,
  output logic [1:0] GPRSel,
  output logic [1:0] WDSel,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       EXTOp,
  output logic [3:0] ALUOp,
  output logic       illegal,
  output logic       timeout
);

  localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic RA_OK = (RA_REG >= 0) && (RA_REG < 32);

  state_t        state;
  state_t        nxt;
  logic [CW-1:0] wcnt;
  cls_t          cls;
  logic          is_bne;
  logic [3:0]    dec_alu;
  logic          dec_ext;
  logic          legal;
  logic          mem_acc;
  logic          tmo;
  logic          hold_alu;

  mc_decode u_dec (
    .op     (Op),
    .funct  (Funct),
    .cls    (cls),
    .is_bne (is_bne),
    .alu_op (dec_alu),
    .ext_op (dec_ext)
  );

  assign legal   = |cls;
  assign mem_acc = (state == S_FETCH) ||
                   (state == S_MEMRD) ||
                   (state == S_MEMWR);
  assign tmo     = (WAIT_MAX != 0) && mem_acc &&
                   (wcnt == CW'(WAIT_MAX));
  assign hold_alu = (state == S_EXEC)   ||
                    (state == S_MEMRD)  ||
                    (state == S_MEMWR)  ||
                    (state == S_WB_ALU) ||
                    (state == S_WB_MEM);

  // Next-state selection; timeouts abort back to FETCH.
  always_comb begin
    nxt = state;
    case (state)
      S_FETCH: begin
        if (tmo)            nxt = S_FETCH;
        else if (mem_ready) nxt = S_DECODE;
      end
      S_DECODE: begin
        if (!legal || cls.j || cls.jal ||
            cls.jr || cls.jalr)
          nxt = S_FETCH;
        else
          nxt = S_EXEC;
      end
      S_EXEC: begin
        if (cls.br)      nxt = S_FETCH;
        else if (cls.lw) nxt = S_MEMRD;
        else if (cls.sw) nxt = S_MEMWR;
        else             nxt = S_WB_ALU;
      end
      S_MEMRD: begin
        if (tmo)            nxt = S_FETCH;
        else if (mem_ready) nxt = S_WB_MEM;
      end
      S_MEMWR: begin
        if (tmo || mem_ready) nxt = S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase
  end

  // State register and wait counter; counter only runs while stalled.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_FETCH;
      wcnt  <= '0;
    end else begin
      state <= nxt;
      if (mem_acc && !mem_ready && !tmo && (WAIT_MAX != 0))
        wcnt <= wcnt + 1'b1;
      else
        wcnt <= '0;
    end
  end

  // Per-state datapath enables; everything forced low during reset.
  always_comb begin
    mem_req  = 1'b0;
    MemWrite = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    NPCOp    = NPC_PLUS4;
    RegWrite = 1'b0;
    GPRSel   = GPRSel_RD;
    WDSel    = WDSel_ALU;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 1'b0;
    EXTOp    = 1'b0;
    ALUOp    = ALU_NOP;
    illegal  = 1'b0;
    timeout  = tmo;
    if (hold_alu) begin
      ALUOp   = dec_alu;
      ALUSrcA = cls.shift;
      ALUSrcB = cls.i_alu | cls.lw | cls.sw;
      EXTOp   = dec_ext;
    end
    case (state)
      S_FETCH: begin
        mem_req = !tmo;
        if (mem_ready && !tmo) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          NPCOp   = NPC_PLUS4;
        end
      end
      S_DECODE: begin
        illegal = !legal;
        if (cls.j || cls.jal) begin
          PCWrite = 1'b1;
          NPCOp   = NPC_JUMP;
        end
        if (cls.jr || cls.jalr) begin
          PCWrite = 1'b1;
          NPCOp   = NPC_JREG;
        end
        if (cls.jal || cls.jalr) begin
          RegWrite = RA_OK;
          GPRSel   = GPRSel_RA;
          WDSel    = WDSel_PC;
        end
      end
      S_EXEC: begin
        if (cls.br) begin
          NPCOp   = NPC_BRANCH;
          PCWrite = is_bne ? !Zero : Zero;
        end
      end
      S_MEMRD: begin
        mem_req = !tmo;
        IorD    = 1'b1;
      end
      S_MEMWR: begin
        mem_req  = !tmo;
        MemWrite = !tmo;
        IorD     = 1'b1;
      end
      S_WB_ALU: begin
        RegWrite = 1'b1;
        WDSel    = WDSel_ALU;
        GPRSel   = cls.i_alu ? GPRSel_RT : GPRSel_RD;
      end
      S_WB_MEM: begin
        RegWrite = 1'b1;
        WDSel    = WDSel_MDR;
        GPRSel   = GPRSel_RT;
      end
      default: ;
    endcase
    if (!rstn) begin
      mem_req  = 1'b0;
      MemWrite = 1'b0;
      IorD     = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      NPCOp    = NPC_PLUS4;
      RegWrite = 1'b0;
      GPRSel   = GPRSel_RD;
      WDSel    = WDSel_ALU;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 1'b0;
      EXTOp    = 1'b0;
      ALUOp    = ALU_NOP;
      illegal  = 1'b0;
      timeout  = 1'b0;
    end
  end

endmodule
